pc_branch_unit: RTL and testbench
=================================

Name: pc_branch_unit

Overview:
- Execute-stage consumer of the 64-bit ALU result and comparison flags.
- Owns the architectural PC register. Resolves conditional branches, JAL and JALR, and produces the next fetch PC and link value.
- Issues a one-cycle flush pulse after any redirect.
- Traps and freezes on a misaligned control-flow target.

Parameters:
- XLEN, 64, datapath and PC width.
- RESET_PC, 64'h0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all state this cycle.
- valid_in  in  1  execute-stage instruction is valid.
- opcode  in  7  execute-stage instruction opcode.
- funct3  in  3  execute-stage funct3.
- imm  in  XLEN  sign-extended B/J immediate.
- ex_pc  in  XLEN  PC of the execute-stage instruction.
- alu_res  in  XLEN  ALU sum; the JALR target source.
- EQ, LT_SN, GT_SN, LT_UN, GT_UN  in  1 each  ALU comparison flags; valid when the ALU subtracts for a branch opcode.
- pc  out  XLEN  current fetch PC (registered).
- link  out  XLEN  ex_pc + 4, for JAL/JALR writeback (combinational).
- taken  out  1  registered; last update was a redirect.
- flush  out  1  registered one-cycle pulse after a redirect.
- trap  out  1  sticky misaligned-target flag.
- illegal  out  1  registered; a branch with funct3 010/011 was seen.

Behaviour:
- Reset: clk and rst_n are the only clock and reset. Reset is asynchronous and active-low. On reset:
  - pc = RESET_PC
  - taken = 0, flush = 0, trap = 0, illegal = 0
  - state = RUN
- States:
  - RUN: normal operation.
  - TRAP: pc frozen, flush = 0, taken = 0. Exit only via reset.
- Stall: when stall = 1, every register holds, including the flush pulse, and no state transition occurs. Stall wins over valid_in.
- Redirect decode: only when valid_in = 1. Opcode 1100011 (branch), selected by funct3:
  - 000 BEQ: EQ
  - 001 BNE: !EQ
  - 100 BLT: LT_SN
  - 101 BGE: !LT_SN
  - 110 BLTU: LT_UN
  - 111 BGEU: !LT_UN
  - 010 / 011: not taken; illegal = 1 for one update.
- Targets:
  - Taken branch and JAL (1101111): target = ex_pc + imm.
  - JALR (1100111): always taken; target = alu_res with bit 0 cleared.
  - All adds are XLEN wide and wrap modulo 2^XLEN.
- RUN, not stalled:
  - If redirect and target[1:0] == 00: pc <= target, taken <= 1, flush <= 1.
  - If redirect and target[1:0] != 00: pc holds, trap <= 1, state <= TRAP, flush <= 0.
  - Otherwise: pc <= pc + 4, taken <= 0, flush <= 0. This also applies when valid_in = 0.
- Flush timing: flush is high for exactly one unstalled cycle after a redirect. Back-to-back redirects keep flush high on each cycle.
- link: combinational from ex_pc; meaningful only for JAL/JALR.
- Reset mid-operation: immediate asynchronous return to the reset values, including clearing trap.

Decomposition:
- Shared package riscv_pkg:
  - Opcode constants OP_BRANCH, OP_JAL, OP_JALR.
  - Branch funct3 constants F3_BEQ..F3_BGEU.
  - State enum {RUN, TRAP}.
  - XLEN default.
- One natural sub-module: branch_cond. It is combinational and maps funct3 + flags to cond_true and cond_illegal.

Test Plan:
- Reset with RESET_PC = 64'h1000, no valid_in, 3 cycles -> pc 1000, 1004, 1008, 100C; flush = 0 throughout.
- BEQ with EQ = 1, ex_pc = 64'h2000, imm = 64'h40 -> next pc = 2040, taken = 1, flush = 1 for one cycle. Same stimulus with EQ = 0 -> pc + 4, flush = 0.
- Signed vs unsigned compare, s1 = -1, s2 = 1 (LT_SN = 1, LT_UN = 0):
  - BLT taken.
  - BGEU taken.
  - BLTU not taken.
  - BGE not taken.
- JALR with alu_res = 64'h3001 -> pc = 3000 (bit 0 cleared), link = ex_pc + 4. JALR with alu_res = 64'h3002 -> trap = 1, pc frozen for 10 cycles, flush = 0; rst_n low -> trap = 0, pc = RESET_PC.
- stall = 1 together with a taken JAL -> pc, taken and flush unchanged. Release stall -> redirect applied on the next edge. Funct3 = 010 branch -> illegal = 1 and pc + 4.
- Wrap-around: pc = 64'hFFFF_FFFF_FFFF_FFFC, no redirect -> pc = 0. JAL with ex_pc = 64'h10, imm = -16 -> pc = 0.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared opcode/funct3 constants and state encoding for the
//               execute-stage PC and branch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN_DEFAULT = 64;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_e;

endpackage
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond
// Description : Combinational branch-condition decode from funct3 and the
//               ALU comparison flags.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       eq_i,
    input  logic       lt_sn_i,
    input  logic       lt_un_i,
    output logic       cond_true_o,
    output logic       cond_illegal_o
);

    always_comb begin
        cond_true_o    = 1'b0;
        cond_illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  cond_true_o = eq_i;
            F3_BNE:  cond_true_o = ~eq_i;
            F3_BLT:  cond_true_o = lt_sn_i;
            F3_BGE:  cond_true_o = ~lt_sn_i;
            F3_BLTU: cond_true_o = lt_un_i;
            F3_BGEU: cond_true_o = ~lt_un_i;
            // 010 and 011 are unassigned branch encodings
            default: cond_illegal_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_branch_unit
// Description : Architectural PC register; resolves branches, JAL and JALR,
//               issues a flush pulse after redirects, traps on misalignment.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_branch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            valid_in,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] alu_res,
    input  logic            EQ,
    input  logic            LT_SN,
    input  logic            GT_SN,
    input  logic            LT_UN,
    input  logic            GT_UN,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] link,
    output logic            taken,
    output logic            flush,
    output logic            trap,
    output logic            illegal
);

    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            taken_q, taken_d;
    logic            flush_q, flush_d;
    logic            trap_q, trap_d;
    logic            illegal_q, illegal_d;

    logic            w_is_branch;
    logic            w_is_jal;
    logic            w_is_jalr;
    logic            w_cond_true;
    logic            w_cond_illegal;
    logic            w_redirect;
    logic            w_misaligned;
    logic [XLEN-1:0] w_target;
    logic            w_unused;

    // GT flags and the JALR target LSB are architecturally irrelevant here
    assign w_unused = ^{GT_SN, GT_UN, alu_res[0]};

    branch_cond u_branch_cond (
        .funct3_i       (funct3),
        .eq_i           (EQ),
        .lt_sn_i        (LT_SN),
        .lt_un_i        (LT_UN),
        .cond_true_o    (w_cond_true),
        .cond_illegal_o (w_cond_illegal)
    );

    assign w_is_branch  = (opcode == OP_BRANCH);
    assign w_is_jal     = (opcode == OP_JAL);
    assign w_is_jalr    = (opcode == OP_JALR);

    assign w_redirect   = valid_in & ((w_is_branch & w_cond_true) | w_is_jal | w_is_jalr);
    assign w_target     = w_is_jalr ? {alu_res[XLEN-1:1], 1'b0} : (ex_pc + imm);
    assign w_misaligned = |w_target[1:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        taken_d   = taken_q;
        flush_d   = flush_q;
        trap_d    = trap_q;
        illegal_d = illegal_q;
        if (!stall) begin
            case (state_q)
                RUN: begin
                    illegal_d = valid_in & w_is_branch & w_cond_illegal;
                    if (w_redirect && !w_misaligned) begin
                        pc_d    = w_target;
                        taken_d = 1'b1;
                        flush_d = 1'b1;
                    end else if (w_redirect) begin
                        // Misaligned target: PC stays on the faulting fetch
                        trap_d  = 1'b1;
                        state_d = TRAP;
                        taken_d = 1'b0;
                        flush_d = 1'b0;
                    end else begin
                        pc_d    = pc_q + c_PC_STEP;
                        taken_d = 1'b0;
                        flush_d = 1'b0;
                    end
                end
                TRAP: begin
                    taken_d   = 1'b0;
                    flush_d   = 1'b0;
                    illegal_d = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            taken_q   <= 1'b0;
            flush_q   <= 1'b0;
            trap_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            taken_q   <= taken_d;
            flush_q   <= flush_d;
            trap_q    <= trap_d;
            illegal_q <= illegal_d;
        end
    end

    assign pc      = pc_q;
    assign link    = ex_pc + c_PC_STEP;
    assign taken   = taken_q;
    assign flush   = flush_q;
    assign trap    = trap_q;
    assign illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_branch_unit
// Description : Directed self-checking bench for pc_branch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_branch_unit;

    localparam int          XLEN     = 64;
    localparam logic [63:0] RESET_PC = 64'h1000;

    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stall;
    logic            valid_in;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] alu_res;
    logic            EQ, LT_SN, GT_SN, LT_UN, GT_UN;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] link;
    logic            taken, flush, trap, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    pc_branch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .valid_in (valid_in),
        .opcode   (opcode),
        .funct3   (funct3),
        .imm      (imm),
        .ex_pc    (ex_pc),
        .alu_res  (alu_res),
        .EQ       (EQ),
        .LT_SN    (LT_SN),
        .GT_SN    (GT_SN),
        .LT_UN    (LT_UN),
        .GT_UN    (GT_UN),
        .pc       (pc),
        .link     (link),
        .taken    (taken),
        .flush    (flush),
        .trap     (trap),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [63:0] p, input logic [63:0] i, input logic [63:0] a);
        valid_in = v;
        opcode   = op;
        funct3   = f3;
        ex_pc    = p;
        imm      = i;
        alu_res  = a;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (pc !== 64'h1000 || taken !== 1'b0 || flush !== 1'b0 || trap !== 1'b0 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: pc=%h t=%b f=%b tr=%b il=%b, required pc=1000 all flags 0",
                     pc, taken, flush, trap, illegal);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if (pc !== 64'h1000 + 64'(4 * k) || flush !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_count%0d: pc=%h flush=%b, required pc=%h flush=0",
                         k, pc, flush, 64'h1000 + 64'(4 * k));
            end
        end
    endtask

    task automatic test_beq();
        EQ = 1'b1;
        drive(1'b1, OP_BR, 3'b000, 64'h2000, 64'h40, 64'h0);
        tick();
        n_checks++;
        if (pc !== 64'h2040 || taken !== 1'b1 || flush !== 1'b1) begin
            n_fail++;
            $display("FAIL beq_taken: pc=%h t=%b f=%b, required pc=2040 t=1 f=1", pc, taken, flush);
        end
        drive(1'b0, OP_BR, 3'b000, 64'h2000, 64'h40, 64'h0);
        tick();
        n_checks++;
        if (pc !== 64'h2044 || taken !== 1'b0 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_flush_pulse: pc=%h t=%b f=%b, required pc=2044 t=0 f=0", pc, taken, flush);
        end
        EQ = 1'b0;
        drive(1'b1, OP_BR, 3'b000, 64'h2000, 64'h40, 64'h0);
        tick();
        n_checks++;
        if (pc !== 64'h2048 || taken !== 1'b0 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_not_taken: pc=%h t=%b f=%b, required pc=2048 t=0 f=0", pc, taken, flush);
        end
    endtask

    task automatic test_signed_unsigned();
        // s1 = -1, s2 = 1: signed less-than, unsigned greater-than
        EQ = 1'b0; LT_SN = 1'b1; GT_SN = 1'b0; LT_UN = 1'b0; GT_UN = 1'b1;
        drive(1'b1, OP_BR, 3'b100, 64'h4000, 64'h20, 64'h0);
        tick();
        n_checks++;
        if (pc !== 64'h4020 || taken !== 1'b1 || flush !== 1'b1) begin
            n_fail++;
            $display("FAIL blt_taken: pc=%h t=%b f=%b, required pc=4020 t=1 f=1", pc, taken, flush);
        end
        drive(1'b1, OP_BR, 3'b111, 64'h5000, 64'h8, 64'h0);
        tick();
        n_checks++;
        if (pc !== 64'h5008 || taken !== 1'b1 || flush !== 1'b1) begin
            n_fail++;
            $display("FAIL bgeu_taken_b2b: pc=%h t=%b f=%b, required pc=5008 t=1 f=1", pc, taken, flush);
        end
        drive(1'b1, OP_BR, 3'b110, 64'h6000, 64'h8, 64'h0);
        tick();
        n_checks++;
        if (pc !== 64'h500C || taken !== 1'b0 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL bltu_not_taken: pc=%h t=%b f=%b, required pc=500c t=0 f=0", pc, taken, flush);
        end
        drive(1'b1, OP_BR, 3'b101, 64'h6000, 64'h8, 64'h0);
        tick();
        n_checks++;
        if (pc !== 64'h5010 || taken !== 1'b0 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL bge_not_taken: pc=%h t=%b f=%b, required pc=5010 t=0 f=0", pc, taken, flush);
        end
        LT_SN = 1'b0; GT_UN = 1'b0;
    endtask

    task automatic test_jalr_trap();
        drive(1'b1, OP_JALR, 3'b000, 64'h6000, 64'h0, 64'h3001);
        #1;
        n_checks++;
        if (link !== 64'h6004) begin
            n_fail++;
            $display("FAIL jalr_link: link=%h, required 6004", link);
        end
        tick();
        n_checks++;
        if (pc !== 64'h3000 || taken !== 1'b1 || flush !== 1'b1 || trap !== 1'b0) begin
            n_fail++;
            $display("FAIL jalr_target: pc=%h t=%b f=%b tr=%b, required pc=3000 t=1 f=1 tr=0",
                     pc, taken, flush, trap);
        end
        drive(1'b1, OP_JALR, 3'b000, 64'h6000, 64'h0, 64'h3002);
        tick();
        n_checks++;
        if (pc !== 64'h3000 || trap !== 1'b1 || flush !== 1'b0 || taken !== 1'b0) begin
            n_fail++;
            $display("FAIL jalr_misaligned: pc=%h tr=%b f=%b t=%b, required pc=3000 tr=1 f=0 t=0",
                     pc, trap, flush, taken);
        end
        // An aligned JAL while trapped must not unfreeze the PC
        drive(1'b1, OP_JAL, 3'b000, 64'h100, 64'h0, 64'h0);
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++;
            if (pc !== 64'h3000 || trap !== 1'b1 || flush !== 1'b0 || taken !== 1'b0) begin
                n_fail++;
                $display("FAIL trap_frozen%0d: pc=%h tr=%b f=%b t=%b, required pc=3000 tr=1 f=0 t=0",
                         k, pc, trap, flush, taken);
            end
        end
        drive(1'b0, OP_JAL, 3'b000, 64'h0, 64'h0, 64'h0);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (trap !== 1'b0 || pc !== 64'h1000) begin
            n_fail++;
            $display("FAIL async_reset: pc=%h tr=%b, required pc=1000 tr=0", pc, trap);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (pc !== 64'h1004 || trap !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_run: pc=%h tr=%b, required pc=1004 tr=0", pc, trap);
        end
    endtask

    task automatic test_stall_illegal();
        drive(1'b1, OP_JAL, 3'b000, 64'h7000, 64'h100, 64'h0);
        tick();
        n_checks++;
        if (pc !== 64'h7100 || taken !== 1'b1 || flush !== 1'b1) begin
            n_fail++;
            $display("FAIL jal_taken: pc=%h t=%b f=%b, required pc=7100 t=1 f=1", pc, taken, flush);
        end
        stall = 1'b1;
        drive(1'b1, OP_JAL, 3'b000, 64'h8000, 64'h200, 64'h0);
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if (pc !== 64'h7100 || taken !== 1'b1 || flush !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d: pc=%h t=%b f=%b, required pc=7100 t=1 f=1",
                         k, pc, taken, flush);
            end
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if (pc !== 64'h8200 || taken !== 1'b1 || flush !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: pc=%h t=%b f=%b, required pc=8200 t=1 f=1", pc, taken, flush);
        end
        drive(1'b0, OP_JAL, 3'b000, 64'h0, 64'h0, 64'h0);
        tick();
        n_checks++;
        if (pc !== 64'h8204 || flush !== 1'b0 || taken !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_jal: pc=%h f=%b t=%b, required pc=8204 f=0 t=0", pc, flush, taken);
        end
        EQ = 1'b1;
        drive(1'b1, OP_BR, 3'b010, 64'h9000, 64'h40, 64'h0);
        tick();
        n_checks++;
        if (pc !== 64'h8208 || illegal !== 1'b1 || taken !== 1'b0 || flush !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_f3: pc=%h il=%b t=%b f=%b, required pc=8208 il=1 t=0 f=0",
                     pc, illegal, taken, flush);
        end
        drive(1'b0, OP_BR, 3'b010, 64'h9000, 64'h40, 64'h0);
        tick();
        n_checks++;
        if (pc !== 64'h820C || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_clear: pc=%h il=%b, required pc=820c il=0", pc, illegal);
        end
        EQ = 1'b0;
    endtask

    task automatic test_wrap();
        drive(1'b1, OP_JAL, 3'b000, 64'hFFFF_FFFF_FFFF_FFF0, 64'hC, 64'h0);
        tick();
        n_checks++;
        if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++;
            $display("FAIL wrap_setup: pc=%h, required fffffffffffffffc", pc);
        end
        drive(1'b0, OP_JAL, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0);
        #1;
        n_checks++;
        if (link !== 64'h0) begin
            n_fail++;
            $display("FAIL link_wrap: link=%h, required 0", link);
        end
        tick();
        n_checks++;
        if (pc !== 64'h0 || taken !== 1'b0) begin
            n_fail++;
            $display("FAIL pc_wrap: pc=%h t=%b, required pc=0 t=0", pc, taken);
        end
        drive(1'b1, OP_JAL, 3'b000, 64'h10, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0);
        tick();
        n_checks++;
        if (pc !== 64'h0 || taken !== 1'b1 || flush !== 1'b1) begin
            n_fail++;
            $display("FAIL jal_wrap: pc=%h t=%b f=%b, required pc=0 t=1 f=1", pc, taken, flush);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        EQ = 1'b0; LT_SN = 1'b0; GT_SN = 1'b0; LT_UN = 1'b0; GT_UN = 1'b0;
        drive(1'b0, 7'b0, 3'b0, 64'h0, 64'h0, 64'h0);
        #12;
        test_reset();
        test_beq();
        test_signed_unsigned();
        test_jalr_trap();
        test_stall_illegal();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
